// File: rtl/protobuf_byte_packer.sv
// Purpose : packs a serialized protobuf byte stream little-endian into 32-bit words with byte strobes; tracks per-message byte length.
// Latency : 1 cycle from the accepted byte that completes a word (lane 3 or in_last) to out_valid.
// Backpr. : in_ready = !out_valid | out_ready; every byte stalls while a held output word is not being drained.
//
// Ports:
//   clock_clk, reset_reset_n        clock, asynchronous active-low reset
//   in_data/in_last/in_valid/in_ready   byte stream input (one byte per handshake)
//   out_data/out_strb/out_last/out_valid/out_ready   packed word output (byte n at [8n+7:8n])
//   msg_len                         bytes accepted in the current / just-finished message (saturating)
//   msg_done                        1-cycle pulse when the word carrying out_last is consumed
//
// Optional build macro: PB_PACKER_TIMEOUT_FLUSH_EN
//   When defined, a partial word that sits idle for IDLE_FLUSH_CYCLES cycles is pushed out
//   with out_last=0. When undefined, partial words leave only on in_last.
module protobuf_byte_packer #(
    parameter int unsigned IDLE_FLUSH_CYCLES = 16,
    parameter int unsigned LEN_W             = 16
) (
    input  logic             clock_clk,
    input  logic             reset_reset_n,
    input  logic [7:0]       in_data,
    input  logic             in_last,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [31:0]      out_data,
    output logic [3:0]       out_strb,
    output logic             out_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [LEN_W-1:0] msg_len,
    output logic             msg_done
);

    // Out-of-range idle threshold is a build error, not a silent wrap of the 8-bit counter.
    if (IDLE_FLUSH_CYCLES < 1 || IDLE_FLUSH_CYCLES > 255) begin : g_bad_idle_cycles
        $error("protobuf_byte_packer: IDLE_FLUSH_CYCLES must be in 1..255");
    end

    localparam logic [LEN_W-1:0] LEN_ONE = {{(LEN_W-1){1'b0}}, 1'b1};

    // Strobe covering lanes 0..l inclusive.
    function automatic logic [3:0] strb_upto(input logic [1:0] l);
        logic [3:0] s;
        case (l)
            2'd0:    s = 4'b0001;
            2'd1:    s = 4'b0011;
            2'd2:    s = 4'b0111;
            default: s = 4'b1111;
        endcase
        return s;
    endfunction

    // Expands a lane strobe into a 32-bit data mask.
    function automatic logic [31:0] strb_mask(input logic [3:0] s);
        return {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    endfunction

    // ---------------------------------------------------------------------------------------
    // State
    // ---------------------------------------------------------------------------------------
    logic [31:0]      acc_q,       acc_d;
    logic [1:0]       lane_q,      lane_d;
    logic [31:0]      out_data_q,  out_data_d;
    logic [3:0]       out_strb_q,  out_strb_d;
    logic             out_last_q,  out_last_d;
    logic             out_valid_q, out_valid_d;
    logic [LEN_W-1:0] msg_len_q,   msg_len_d;
    logic             msg_done_q,  msg_done_d;
    // Set once the in_last byte is taken: the next accepted byte restarts msg_len at 1.
    logic             new_msg_q,   new_msg_d;

    logic        byte_acc;
    logic        byte_done;
    logic        out_fire;
    logic        flush_go;
    logic [31:0] merged;
    logic [3:0]  done_strb;
    logic [3:0]  flush_strb;

    // ---------------------------------------------------------------------------------------
    // Idle flush
    // ---------------------------------------------------------------------------------------
`ifdef PB_PACKER_TIMEOUT_FLUSH_EN
    // The counter holds the number of idle cycles already completed, so the flush fires on
    // the edge that ends the IDLE_FLUSH_CYCLES-th idle cycle.
    localparam logic [7:0] IDLE_THRESH = 8'(IDLE_FLUSH_CYCLES - 1);

    logic [7:0] idle_cnt_q, idle_cnt_d;

    always_comb begin
        idle_cnt_d = idle_cnt_q;
        flush_go   = 1'b0;
        if (byte_acc || lane_q == 2'd0) begin
            // An accepted byte always wins over a pending flush.
            idle_cnt_d = 8'd0;
        end else if (idle_cnt_q >= IDLE_THRESH) begin
            // Threshold reached: flush only once the output register is free or draining,
            // otherwise park at the threshold and retry next cycle.
            if (!out_valid_q || out_ready) begin
                flush_go   = 1'b1;
                idle_cnt_d = 8'd0;
            end
        end else begin
            idle_cnt_d = idle_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clock_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            idle_cnt_q <= 8'd0;
        end else begin
            idle_cnt_q <= idle_cnt_d;
        end
    end
`else
    assign flush_go = 1'b0;
`endif

    // ---------------------------------------------------------------------------------------
    // Datapath and control
    // ---------------------------------------------------------------------------------------
    always_comb begin
        in_ready   = !out_valid_q || out_ready;
        byte_acc   = in_valid && in_ready;
        out_fire   = out_valid_q && out_ready;
        byte_done  = byte_acc && ((lane_q == 2'd3) || in_last);
        done_strb  = strb_upto(lane_q);
        // Only evaluated when lane_q != 0, so lane_q-1 never wraps in use.
        flush_strb = strb_upto(lane_q - 2'd1);

        merged = acc_q;
        merged[{lane_q, 3'b000} +: 8] = in_data;

        acc_d       = acc_q;
        lane_d      = lane_q;
        out_data_d  = out_data_q;
        out_strb_d  = out_strb_q;
        out_last_d  = out_last_q;
        out_valid_d = out_valid_q;
        msg_len_d   = msg_len_q;
        new_msg_d   = new_msg_q;
        msg_done_d  = out_fire && out_last_q;

        if (byte_acc) begin
            if (new_msg_q) begin
                msg_len_d = LEN_ONE;
            end else if (msg_len_q != {LEN_W{1'b1}}) begin
                msg_len_d = msg_len_q + LEN_ONE;
            end
            new_msg_d = in_last;

            if (byte_done) begin
                acc_d  = 32'd0;
                lane_d = 2'd0;
            end else begin
                acc_d  = merged;
                lane_d = lane_q + 2'd1;
            end
        end

        if (out_fire) begin
            out_valid_d = 1'b0;
        end

        // A load in the same cycle as a drain overrides the clear, so full-rate traffic
        // never shows a bubble on out_valid. in_ready guarantees the register is free here.
        if (byte_done) begin
            out_data_d  = merged & strb_mask(done_strb);
            out_strb_d  = done_strb;
            out_last_d  = in_last;
            out_valid_d = 1'b1;
        end else if (flush_go) begin
            out_data_d  = acc_q & strb_mask(flush_strb);
            out_strb_d  = flush_strb;
            out_last_d  = 1'b0;
            out_valid_d = 1'b1;
            acc_d       = 32'd0;
            lane_d      = 2'd0;
        end
    end

    always_ff @(posedge clock_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            acc_q       <= 32'd0;
            lane_q      <= 2'd0;
            out_data_q  <= 32'd0;
            out_strb_q  <= 4'd0;
            out_last_q  <= 1'b0;
            out_valid_q <= 1'b0;
            msg_len_q   <= '0;
            msg_done_q  <= 1'b0;
            new_msg_q   <= 1'b1;
        end else begin
            acc_q       <= acc_d;
            lane_q      <= lane_d;
            out_data_q  <= out_data_d;
            out_strb_q  <= out_strb_d;
            out_last_q  <= out_last_d;
            out_valid_q <= out_valid_d;
            msg_len_q   <= msg_len_d;
            msg_done_q  <= msg_done_d;
            new_msg_q   <= new_msg_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_strb  = out_strb_q;
    assign out_last  = out_last_q;
    assign out_valid = out_valid_q;
    assign msg_len   = msg_len_q;
    assign msg_done  = msg_done_q;

endmodule

// File: tb/tb_protobuf_byte_packer.sv
// Purpose : directed self-checking bench for protobuf_byte_packer.
// Latency : outputs sampled on the falling edge, one half-cycle after the active edge.
// Backpr. : out_ready driven per step; byte sends wait (bounded) for in_ready.
module tb_protobuf_byte_packer;

    logic        clk;
    logic        rst_n;
    logic [7:0]  in_data;
    logic        in_last;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] out_data;
    logic [3:0]  out_strb;
    logic        out_last;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] msg_len;
    logic        msg_done;

    int checks   = 0;
    int failures = 0;
    int stall_cycles = 0;
    int done_cnt = 0;

    logic [31:0] q_data[$];
    logic [3:0]  q_strb[$];
    logic        q_last[$];

    protobuf_byte_packer #(
        .IDLE_FLUSH_CYCLES(16),
        .LEN_W(16)
    ) dut (
        .clock_clk     (clk),
        .reset_reset_n (rst_n),
        .in_data       (in_data),
        .in_last       (in_last),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .out_data      (out_data),
        .out_strb      (out_strb),
        .out_last      (out_last),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .msg_len       (msg_len),
        .msg_done      (msg_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Records every consumed word and every msg_done pulse.
    always @(posedge clk) begin
        if (rst_n) begin
            if (out_valid && out_ready) begin
                q_data.push_back(out_data);
                q_strb.push_back(out_strb);
                q_last.push_back(out_last);
            end
            if (msg_done) done_cnt++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_mon();
        q_data.delete();
        q_strb.delete();
        q_last.delete();
        done_cnt = 0;
    endtask

    // Called at a falling edge; returns at the falling edge after the byte is accepted.
    task automatic send(input logic [7:0] b, input logic l);
        int  n;
        bit  ok;
        n  = 0;
        ok = 1'b0;
        in_valid = 1'b1;
        in_data  = b;
        in_last  = l;
        while (!ok && n < 200) begin
            @(posedge clk);
            if (in_ready) ok = 1'b1;
            else n++;
        end
        stall_cycles += n;
        if (!ok) begin
            checks++;
            failures++;
            $error("FAIL send_timeout observed=%h expected=accepted", b);
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic chk_word(input string tag, input int idx, input logic [31:0] d,
                            input logic [3:0] s, input logic l);
        if (idx < q_data.size()) begin
            chk({tag, "_data"}, q_data[idx], d);
            chk({tag, "_strb"}, 32'(q_strb[idx]), 32'(s));
            chk({tag, "_last"}, 32'(q_last[idx]), 32'(l));
        end else begin
            checks++;
            failures++;
            $error("FAIL %s_missing observed=%0d words expected>%0d", tag, q_data.size(), idx);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        in_data   = 8'h00;
        in_last   = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;

        // ---- Reset state ----
        cyc(2);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data",  out_data, 32'd0);
        chk("rst_out_strb",  32'(out_strb), 32'd0);
        chk("rst_out_last",  32'(out_last), 32'd0);
        chk("rst_msg_len",   32'(msg_len), 32'd0);
        chk("rst_msg_done",  32'(msg_done), 32'd0);
        chk("rst_in_ready",  32'(in_ready), 32'd1);
        rst_n = 1'b1;
        cyc(2);

        // ---- 1: five-byte message ----
        clear_mon();
        send(8'h01, 1'b0);
        send(8'h02, 1'b0);
        send(8'h03, 1'b0);
        send(8'h04, 1'b0);
        send(8'h05, 1'b1);
        cyc(3);
        chk("t1_words", 32'(q_data.size()), 32'd2);
        chk_word("t1_w0", 0, 32'h04030201, 4'hF, 1'b0);
        chk_word("t1_w1", 1, 32'h00000005, 4'h1, 1'b1);
        chk("t1_msg_len", 32'(msg_len), 32'd5);
        chk("t1_done_cnt", 32'(done_cnt), 32'd1);

        // ---- Ignored inputs while in_valid=0 ----
        in_data = 8'hFF;
        in_last = 1'b1;
        cyc(3);
        chk("idle_msg_len",   32'(msg_len), 32'd5);
        chk("idle_out_valid", 32'(out_valid), 32'd0);
        in_last = 1'b0;

        // ---- 2: single-byte message, 1-cycle latency ----
        clear_mon();
        send(8'hAA, 1'b1);
        chk("t2_out_valid", 32'(out_valid), 32'd1);
        chk("t2_out_data",  out_data, 32'h000000AA);
        chk("t2_out_strb",  32'(out_strb), 32'h1);
        chk("t2_out_last",  32'(out_last), 32'd1);
        chk("t2_msg_len",   32'(msg_len), 32'd1);
        cyc(3);
        chk("t2_done_cnt",  32'(done_cnt), 32'd1);

        // ---- 3: output stall of 10 cycles ----
        clear_mon();
        out_ready = 1'b0;
        send(8'h10, 1'b0);
        send(8'h11, 1'b0);
        send(8'h12, 1'b0);
        send(8'h13, 1'b0);
        in_valid = 1'b1;
        in_data  = 8'h14;
        for (int i = 0; i < 10; i++) begin
            cyc(1);
            chk("t3_stall_in_ready",  32'(in_ready), 32'd0);
            chk("t3_stall_out_valid", 32'(out_valid), 32'd1);
            chk("t3_stall_out_data",  out_data, 32'h13121110);
            chk("t3_stall_out_strb",  32'(out_strb), 32'hF);
        end
        chk("t3_stall_msg_len", 32'(msg_len), 32'd4);
        out_ready = 1'b1;
        send(8'h14, 1'b0);
        send(8'h15, 1'b0);
        send(8'h16, 1'b0);
        send(8'h17, 1'b1);
        cyc(3);
        chk("t3_words", 32'(q_data.size()), 32'd2);
        chk_word("t3_w0", 0, 32'h13121110, 4'hF, 1'b0);
        chk_word("t3_w1", 1, 32'h17161514, 4'hF, 1'b1);
        chk("t3_msg_len", 32'(msg_len), 32'd8);

        // ---- 4: full rate, 12 bytes ----
        clear_mon();
        stall_cycles = 0;
        for (int i = 0; i < 12; i++) begin
            send(8'(8'h20 + i), (i == 11));
        end
        chk("t4_stall_cycles", 32'(stall_cycles), 32'd0);
        cyc(3);
        chk("t4_words", 32'(q_data.size()), 32'd3);
        chk_word("t4_w0", 0, 32'h23222120, 4'hF, 1'b0);
        chk_word("t4_w1", 1, 32'h27262524, 4'hF, 1'b0);
        chk_word("t4_w2", 2, 32'h2B2A2928, 4'hF, 1'b1);
        chk("t4_msg_len",  32'(msg_len), 32'd12);
        chk("t4_done_cnt", 32'(done_cnt), 32'd1);

        // ---- 5: partial word left idle ----
        clear_mon();
        send(8'h11, 1'b0);
        send(8'h22, 1'b0);
`ifdef PB_PACKER_TIMEOUT_FLUSH_EN
        cyc(15);
        chk("t5_pre_flush_valid", 32'(out_valid), 32'd0);
        cyc(1);
        chk("t5_flush_valid", 32'(out_valid), 32'd1);
        chk("t5_flush_data",  out_data, 32'h00002211);
        chk("t5_flush_strb",  32'(out_strb), 32'h3);
        chk("t5_flush_last",  32'(out_last), 32'd0);
        chk("t5_flush_len",   32'(msg_len), 32'd2);
        cyc(2);
        send(8'h33, 1'b1);
        chk("t5_tail_data", out_data, 32'h00000033);
        chk("t5_tail_strb", 32'(out_strb), 32'h1);
        chk("t5_tail_last", 32'(out_last), 32'd1);
`else
        cyc(40);
        chk("t5_no_flush_valid", 32'(out_valid), 32'd0);
        chk("t5_no_flush_words", 32'(q_data.size()), 32'd0);
        send(8'h33, 1'b1);
        chk("t5_tail_data", out_data, 32'h00332211);
        chk("t5_tail_strb", 32'(out_strb), 32'h7);
        chk("t5_tail_last", 32'(out_last), 32'd1);
`endif
        chk("t5_msg_len", 32'(msg_len), 32'd3);
        cyc(3);

        // ---- 6: reset mid-message ----
        clear_mon();
        send(8'h01, 1'b0);
        send(8'h02, 1'b0);
        send(8'h03, 1'b0);
        chk("t6_pre_rst_len", 32'(msg_len), 32'd3);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_out_valid", 32'(out_valid), 32'd0);
        chk("t6_rst_out_data",  out_data, 32'd0);
        chk("t6_rst_msg_len",   32'(msg_len), 32'd0);
        chk("t6_rst_in_ready",  32'(in_ready), 32'd1);
        cyc(2);
        rst_n = 1'b1;
        cyc(1);
        send(8'h7E, 1'b1);
        chk("t6_out_valid", 32'(out_valid), 32'd1);
        chk("t6_out_data",  out_data, 32'h0000007E);
        chk("t6_out_strb",  32'(out_strb), 32'h1);
        chk("t6_out_last",  32'(out_last), 32'd1);
        chk("t6_msg_len",   32'(msg_len), 32'd1);
        cyc(3);
        chk("t6_words", 32'(q_data.size()), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
